// File: rtl/lsu_io_pkg.sv
// Shared constants, types and helpers for the LSU memory-mapped input block.
package lsu_io_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int N_BTN  = 4;
    localparam int N_EVT  = 5;

    localparam logic [15:0] SW_ADDR   = 16'h7800;
    localparam logic [15:0] BTN_ADDR  = 16'h7810;
    localparam logic [15:0] FLAG_ADDR = 16'h7820;

    localparam int EVT_BTN0 = 0;
    localparam int EVT_BTN1 = 1;
    localparam int EVT_BTN2 = 2;
    localparam int EVT_BTN3 = 3;
    localparam int EVT_SW   = 4;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } btn_state_e;

    // A read of the flag register clears everything; a write clears only the ones written.
    function automatic logic [N_EVT-1:0] clear_mask(input logic rd, input logic wr,
                                                    input logic acc, input logic [N_EVT-1:0] w1c);
        return ((acc && rd) ? 5'b11111 : 5'b00000) | ((acc && wr) ? w1c : 5'b00000);
    endfunction

endpackage

// File: rtl/input_event_ctrl_if.sv
// LSU load/store bus as seen by the input-event controller.
interface input_event_ctrl_if;
    import lsu_io_pkg::*;

    logic [ADDR_W-1:0] i_addr;
    logic              i_rd_en;
    logic              i_lsu_wren;
    logic [DATA_W-1:0] i_wdata;

    modport master (output i_addr, output i_rd_en, output i_lsu_wren, output i_wdata);
    modport slave  (input  i_addr, input  i_rd_en, input  i_lsu_wren, input  i_wdata);
endinterface

// File: rtl/input_event_ctrl_btn_debounce.sv
// One push-button: two-flop synchroniser, debounce FSM and hold counter.
module btn_debounce
    import lsu_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             btn_sync_q;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_d;

    // Next-state logic; the press pulse is the accepted IDLE_LO->IDLE_HI transition itself.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            IDLE_LO: begin
                if (btn_sync_q) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE_LO;
                end
            end
            WAIT_HI: begin
                if (!btn_sync_q) begin
                    state_d = IDLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_HI;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            IDLE_HI: begin
                if (!btn_sync_q) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE_HI;
                end
            end
            WAIT_LO: begin
                if (btn_sync_q) begin
                    state_d = IDLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE_LO;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end
        endcase
        level_d = (state_d == IDLE_HI) || (state_d == WAIT_LO);
    end

    // Synchroniser, FSM state, counter and registered level.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sync1_q    <= 1'b0;
            btn_sync_q <= 1'b0;
            state_q    <= IDLE_LO;
            cnt_q      <= '0;
            level_q    <= 1'b0;
        end else begin
            sync1_q    <= i_btn;
            btn_sync_q <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_press = press_d;

endmodule

// File: rtl/input_event_ctrl.sv
// Input buffer sequencing: debounced buttons, synchronised switches,
// sticky event flags with read/W1C clearing and a one-cycle ready pulse.
module input_event_ctrl #(
    parameter int          DEBOUNCE_CYCLES = 20,
    parameter int          CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter logic [15:0] FLAG_ADDR       = lsu_io_pkg::FLAG_ADDR
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [3:0]          i_io_btn,
    input  logic [31:0]         i_io_sw,
    input_event_ctrl_if.slave   bus,
    output logic [3:0]          o_btn_db,
    output logic [31:0]         o_sw_sync,
    output logic [4:0]          o_evt_pending,
    output logic                o_ack
);
    import lsu_io_pkg::*;

    logic [N_BTN-1:0] btn_level_s;
    logic [N_BTN-1:0] btn_press_s;
    logic [31:0]      sw_meta_q, sw_sync_q, sw_prev_q;
    logic [N_EVT-1:0] pending_q, pending_d;
    logic [N_EVT-1:0] set_s, clr_s;
    logic             ack_q, ack_d;
    logic             acc_s, sw_evt_s;
    logic             unused_bus_bits;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_btn_debounce (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_btn   (i_io_btn[g]),
            .o_level (btn_level_s[g]),
            .o_press (btn_press_s[g])
        );
    end

    // Event set/clear; a set in the same cycle as a clear takes priority.
    always_comb begin
        acc_s     = (bus.i_addr[15:0] == FLAG_ADDR);
        sw_evt_s  = (sw_sync_q != sw_prev_q);
        set_s     = {sw_evt_s, btn_press_s};
        clr_s     = clear_mask(bus.i_rd_en, bus.i_lsu_wren, acc_s, bus.i_wdata[N_EVT-1:0]);
        pending_d = (pending_q & ~clr_s) | set_s;
        ack_d     = |set_s;
    end

    // Switch synchroniser, change-detect history, pending flags and ack.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            sw_meta_q <= 32'h0000_0000;
            sw_sync_q <= 32'h0000_0000;
            sw_prev_q <= 32'h0000_0000;
            pending_q <= 5'b00000;
            ack_q     <= 1'b0;
        end else begin
            sw_meta_q <= i_io_sw;
            sw_sync_q <= sw_meta_q;
            sw_prev_q <= sw_sync_q;
            pending_q <= pending_d;
            ack_q     <= ack_d;
        end
    end

    assign unused_bus_bits = ^{bus.i_addr[31:16], bus.i_wdata[31:N_EVT]};

    assign o_btn_db      = btn_level_s;
    assign o_sw_sync     = sw_sync_q;
    assign o_evt_pending = pending_q;
    assign o_ack         = ack_q;

endmodule

// File: tb/tb_input_event_ctrl.sv
// Directed, table-driven bench for input_event_ctrl with DEBOUNCE_CYCLES=4.
module tb_input_event_ctrl;
    import lsu_io_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btn;
    logic [31:0] sw;
    logic [3:0]  db;
    logic [31:0] sws;
    logic [4:0]  pend;
    logic        ack;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0]  btn;
        logic [31:0] sw;
        logic [31:0] addr;
        logic        rd;
        logic [3:0]  e_db;
        logic [31:0] e_sw;
        logic [4:0]  e_p;
        logic        e_ack;
    } vec_t;

    vec_t vecs[$];

    input_event_ctrl_if bus_if();

    input_event_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_io_btn      (btn),
        .i_io_sw       (sw),
        .bus           (bus_if),
        .o_btn_db      (db),
        .o_sw_sync     (sws),
        .o_evt_pending (pend),
        .o_ack         (ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] b, input logic [31:0] s, input logic [31:0] a,
                         input logic rd, input logic wr, input logic [31:0] wd);
        btn = b;
        sw  = s;
        bus_if.i_addr     = a;
        bus_if.i_rd_en    = rd;
        bus_if.i_lsu_wren = wr;
        bus_if.i_wdata    = wd;
    endtask

    task automatic check(input string name, input logic [3:0] e_db, input logic [31:0] e_sw,
                         input logic [4:0] e_p, input logic e_ack);
        checks++;
        if ({db, sws, pend, ack} !== {e_db, e_sw, e_p, e_ack}) begin
            errors++;
            $display("FAIL %s: got db=%b sw=%h pend=%b ack=%b, expected db=%b sw=%h pend=%b ack=%b",
                     name, db, sws, pend, ack, e_db, e_sw, e_p, e_ack);
        end
    endtask

    task automatic add(input logic [3:0] b, input logic [31:0] s, input logic [31:0] a, input logic rd,
                       input logic [3:0] e_db, input logic [31:0] e_sw, input logic [4:0] e_p, input logic e_ack);
        vec_t v;
        v.btn = b; v.sw = s; v.addr = a; v.rd = rd;
        v.e_db = e_db; v.e_sw = e_sw; v.e_p = e_p; v.e_ack = e_ack;
        vecs.push_back(v);
    endtask

    initial begin
        // Clean press of btn0: accepted on the 7th edge.
        for (int i = 0; i < 6; i++) add(4'b0001, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'b00000, 1'b0);
        add(4'b0001, 32'h0, 32'h0, 1'b0, 4'b0001, 32'h0, 5'b00001, 1'b1);
        add(4'b0001, 32'h0, 32'h0, 1'b0, 4'b0001, 32'h0, 5'b00001, 1'b0);
        // Release: level drops on the 7th edge, no event.
        for (int i = 0; i < 6; i++) add(4'b0000, 32'h0, 32'h0, 1'b0, 4'b0001, 32'h0, 5'b00001, 1'b0);
        add(4'b0000, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'b00001, 1'b0);
        add(4'b0000, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0, 5'b00001, 1'b0);
        // Switch change.
        add(4'b0000, 32'hA5, 32'h0, 1'b0, 4'b0000, 32'h0,  5'b00001, 1'b0);
        add(4'b0000, 32'hA5, 32'h0, 1'b0, 4'b0000, 32'hA5, 5'b00001, 1'b0);
        add(4'b0000, 32'hA5, 32'h0, 1'b0, 4'b0000, 32'hA5, 5'b10001, 1'b1);
        add(4'b0000, 32'hA5, 32'h0, 1'b0, 4'b0000, 32'hA5, 5'b10001, 1'b0);
        // btn1 press collides with a flag read: read clears, press survives.
        for (int i = 0; i < 6; i++) add(4'b0010, 32'hA5, 32'h0, 1'b0, 4'b0000, 32'hA5, 5'b10001, 1'b0);
        add(4'b0010, 32'hA5, 32'h0000_7820, 1'b1, 4'b0010, 32'hA5, 5'b00010, 1'b1);
        add(4'b0010, 32'hA5, 32'h0000_7800, 1'b1, 4'b0010, 32'hA5, 5'b00010, 1'b0);
        add(4'b0010, 32'hA5, 32'h0000_7810, 1'b1, 4'b0010, 32'hA5, 5'b00010, 1'b0);

        // Reset with toggling inputs.
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(4'($urandom), $urandom, 32'h0000_7820, 1'($urandom), 1'($urandom), $urandom);
            tick();
            check($sformatf("reset%0d", i), 4'b0000, 32'h0, 5'b00000, 1'b0);
        end
        drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("idle%0d", i), 4'b0000, 32'h0, 5'b00000, 1'b0);
        end

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].btn, vecs[i].sw, vecs[i].addr, vecs[i].rd, 1'b0, 32'h0);
            tick();
            check($sformatf("vec%0d", i), vecs[i].e_db, vecs[i].e_sw, vecs[i].e_p, vecs[i].e_ack);
        end

        // Bounce on btn2 (btn1 still held): 2 high, 2 low, then steady high.
        for (int t = 1; t <= 11; t++) begin
            drive((t == 3 || t == 4) ? 4'b0010 : 4'b0110, 32'hA5, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            if (t < 11) check($sformatf("bounce%0d", t), 4'b0010, 32'hA5, 5'b00010, 1'b0);
            else        check("bounce_accept", 4'b0110, 32'hA5, 5'b00110, 1'b1);
        end

        // btn0/btn3 press and a switch change together fill every pending bit.
        for (int t = 1; t <= 7; t++) begin
            drive(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            check($sformatf("fill%0d", t), (t >= 7) ? 4'b1111 : 4'b0110,
                  (t >= 2) ? 32'h0 : 32'hA5,
                  (t >= 7) ? 5'b11111 : ((t >= 3) ? 5'b10110 : 5'b00110),
                  (t == 3 || t == 7) ? 1'b1 : 1'b0);
        end

        // Write-one-to-clear bits 0 and 2.
        drive(4'b1111, 32'h0, 32'h0000_7820, 1'b0, 1'b1, 32'h0000_0005);
        tick();
        check("w1c", 4'b1111, 32'h0, 5'b11010, 1'b0);

        // Switch change on an already-pending bit still pulses ack.
        for (int t = 1; t <= 3; t++) begin
            drive(4'b1111, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            check($sformatf("resw%0d", t), 4'b1111, (t >= 2) ? 32'h1 : 32'h0, 5'b11010, (t == 3) ? 1'b1 : 1'b0);
        end

        // Read plus write together, upper address bits set: union clears all.
        drive(4'b1111, 32'h1, 32'hFFFF_7820, 1'b1, 1'b1, 32'h0000_0005);
        tick();
        check("rd_wr_union", 4'b1111, 32'h1, 5'b00000, 1'b0);

        // Release all buttons, then reset in the middle of a WAIT_HI.
        for (int t = 1; t <= 7; t++) begin
            drive(4'b0000, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check("release_all", 4'b0000, 32'h1, 5'b00000, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            drive(4'b0001, 32'h1, 32'h0, 1'b0, 1'b0, 32'h0);
            tick();
        end
        check("wait_hi", 4'b0000, 32'h1, 5'b00000, 1'b0);
        drive(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        check("mid_reset", 4'b0000, 32'h0, 5'b00000, 1'b0);
        rst = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            check($sformatf("post_reset%0d", t), 4'b0000, 32'h0, 5'b00000, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
